// File: rtl/pong_pkg.sv
// Shared Pong field geometry, rally timing, FSM state codes and direction constants.
// Paddle controllers and the ball engine both import this package.
package pong_pkg;

    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned BALL        = 8;
    localparam int unsigned STEP        = 2;
    localparam int unsigned PADDLE_W    = 26;
    localparam int unsigned PADDLE_H    = 56;
    localparam int unsigned RIGHT_X     = 614;
    localparam int unsigned SERVE_TICKS = 60;
    localparam int unsigned HOLD_TICKS  = 60;
    localparam int unsigned WIN_SCORE   = 9;

    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned TIMER_W = 6;
    localparam int unsigned CMP_W   = 11;

    localparam int unsigned CENTRE_X = (SCREEN_W - BALL) / 2;
    localparam int unsigned CENTRE_Y = (SCREEN_H - BALL) / 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SERVE     = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_SCORED    = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Score increment that never runs past the winning score.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= SCORE_W'(WIN_SCORE)) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter advanced only on frame ticks; done is high while the count is zero.
// Load wins over a coincident tick.
module tick_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    logic [W-1:0] count_q, count_d;
    logic         done_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            done_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            done_q  <= (count_d == '0);
        end
    end

    assign count_o = count_q;
    assign done_o  = done_q;

endmodule

// File: rtl/ball_engine.sv
// Pong ball physics and rally control: moves the ball once per frame tick, bounces off
// walls and paddle faces, detects misses, keeps score and sequences serve/hold/game-over.
module ball_engine
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic [Y_W-1:0]     pad0Y,
    input  logic [Y_W-1:0]     pad1Y,
    output logic [X_W-1:0]     ballX,
    output logic [Y_W-1:0]     ballY,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [1:0]         point,
    output logic               playing,
    output logic               gameOver,
    output logic               winner
);

    logic [2:0]         state_q, state_d;
    logic [X_W-1:0]     ball_x_q, ball_x_d;
    logic [Y_W-1:0]     ball_y_q, ball_y_d;
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    logic [SCORE_W-1:0] score0_q, score0_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [1:0]         point_q, point_d;
    logic               playing_q, playing_d;
    logic               game_over_q, game_over_d;
    logic               winner_q, winner_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic [TIMER_W-1:0] tmr_count;
    logic               tmr_done;
    logic               expire_c;

    tick_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .count_o    (tmr_count),
        .done_o     (tmr_done)
    );

    // A countdown finishes on the tick that takes it from 1 to 0.
    assign expire_c = tick && (tmr_done || (tmr_count == TIMER_W'(1)));

    // All geometry compares run on 11-bit zero-extended values so sums cannot wrap.
    logic [CMP_W-1:0] x_w, y_w, p0_w, p1_w;
    logic             overlap0_c, overlap1_c;
    logic             hit0_c, miss0_c, hit1_c, miss1_c;

    assign x_w  = CMP_W'(ball_x_q);
    assign y_w  = CMP_W'(ball_y_q);
    assign p0_w = CMP_W'(pad0Y);
    assign p1_w = CMP_W'(pad1Y);

    assign overlap0_c = (y_w + CMP_W'(BALL) > p0_w) && (y_w < p0_w + CMP_W'(PADDLE_H));
    assign overlap1_c = (y_w + CMP_W'(BALL) > p1_w) && (y_w < p1_w + CMP_W'(PADDLE_H));

    assign hit0_c  = (x_w >= CMP_W'(PADDLE_W)) && (x_w - CMP_W'(STEP) < CMP_W'(PADDLE_W))
                     && overlap0_c;
    assign miss0_c = (x_w < CMP_W'(STEP));
    assign hit1_c  = (x_w + CMP_W'(BALL) <= CMP_W'(RIGHT_X))
                     && (x_w + CMP_W'(BALL) + CMP_W'(STEP) > CMP_W'(RIGHT_X)) && overlap1_c;
    assign miss1_c = (x_w + CMP_W'(BALL) + CMP_W'(STEP) > CMP_W'(SCREEN_W));

    // Vertical motion with wall bounce, applied independently of the horizontal outcome.
    logic [Y_W-1:0] y_mv;
    logic           dy_mv;

    always_comb begin
        y_mv  = ball_y_q;
        dy_mv = dir_y_q;
        if (dir_y_q == DIR_UP) begin
            if (y_w < CMP_W'(STEP)) begin
                y_mv  = '0;
                dy_mv = DIR_DOWN;
            end else begin
                y_mv = ball_y_q - Y_W'(STEP);
            end
        end else begin
            if (y_w + CMP_W'(BALL) + CMP_W'(STEP) > CMP_W'(SCREEN_H)) begin
                y_mv  = Y_W'(SCREEN_H - BALL);
                dy_mv = DIR_UP;
            end else begin
                y_mv = ball_y_q + Y_W'(STEP);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        score0_d = score0_q;
        score1_d = score1_q;
        point_d  = 2'b00;
        winner_d = winner_q;
        tmr_load = 1'b0;
        tmr_val  = TIMER_W'(SERVE_TICKS);

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                ball_x_d = X_W'(CENTRE_X);
                ball_y_d = Y_W'(CENTRE_Y);
                if (start) begin
                    state_d  = ST_SERVE;
                    score0_d = '0;
                    score1_d = '0;
                    dir_x_d  = DIR_RIGHT;
                    tmr_load = 1'b1;
                end
            end
            ST_SERVE: begin
                if (expire_c) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    ball_y_d = y_mv;
                    dir_y_d  = dy_mv;
                    if (dir_x_q == DIR_LEFT) begin
                        if (hit0_c) begin
                            ball_x_d = X_W'(PADDLE_W);
                            dir_x_d  = DIR_RIGHT;
                        end else if (miss0_c) begin
                            score1_d = sat_inc(score1_q);
                            point_d  = 2'b10;
                            dir_x_d  = DIR_LEFT;
                            tmr_load = 1'b1;
                            tmr_val  = TIMER_W'(HOLD_TICKS);
                            state_d  = ST_SCORED;
                        end else begin
                            ball_x_d = ball_x_q - X_W'(STEP);
                        end
                    end else begin
                        if (hit1_c) begin
                            ball_x_d = X_W'(RIGHT_X - BALL);
                            dir_x_d  = DIR_LEFT;
                        end else if (miss1_c) begin
                            score0_d = sat_inc(score0_q);
                            point_d  = 2'b01;
                            dir_x_d  = DIR_RIGHT;
                            tmr_load = 1'b1;
                            tmr_val  = TIMER_W'(HOLD_TICKS);
                            state_d  = ST_SCORED;
                        end else begin
                            ball_x_d = ball_x_q + X_W'(STEP);
                        end
                    end
                end
            end
            ST_SCORED: begin
                if (expire_c) begin
                    ball_x_d = X_W'(CENTRE_X);
                    ball_y_d = Y_W'(CENTRE_Y);
                    if ((score0_q >= SCORE_W'(WIN_SCORE)) || (score1_q >= SCORE_W'(WIN_SCORE))) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = (score1_q >= SCORE_W'(WIN_SCORE));
                    end else begin
                        state_d  = ST_SERVE;
                        tmr_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign playing_d   = (state_d == ST_PLAY);
    assign game_over_d = (state_d == ST_GAME_OVER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ball_x_q    <= X_W'(CENTRE_X);
            ball_y_q    <= Y_W'(CENTRE_Y);
            dir_x_q     <= DIR_RIGHT;
            dir_y_q     <= DIR_DOWN;
            score0_q    <= '0;
            score1_q    <= '0;
            point_q     <= 2'b00;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            score0_q    <= score0_d;
            score1_q    <= score1_d;
            point_q     <= point_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign ballX    = ball_x_q;
    assign ballY    = ball_y_q;
    assign score0   = score0_q;
    assign score1   = score1_q;
    assign point    = point_q;
    assign playing  = playing_q;
    assign gameOver = game_over_q;
    assign winner   = winner_q;

endmodule
